signal_history_tracker: RTL and testbench

Timestamped history recorder for one pipeline-status bit in the instruction-trace tracker. Every qualified cycle in which the tracked signal is high, the block stores the free-running cycle counter value in a circular history. On request it answers two retrospective queries over an inclusive time window: "did the signal fire in this window?" and "at what time did it first fire in this window?". Stage trackers use it to locate jump, illegal-instruction and branch-decision events after the fact.

---
 rtl/signal_history_tracker_pkg.sv | 8 +
 rtl/signal_history_tracker_ts_window_match.sv | 15 +
 rtl/signal_history_tracker.sv | 75 +++++++
 tb/tb_signal_history_tracker.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/signal_history_tracker_pkg.sv
// signal_history_tracker_pkg: shared trace types (signed timestamp, query window, no-match constant)
package signal_history_tracker_pkg;
    localparam int TS_WIDTH = 32;
    typedef logic signed [TS_WIDTH-1:0] ts_t;
    // [1] = window start, [0] = window end, both inclusive
    typedef ts_t [1:0] window_t;
    localparam ts_t NO_MATCH = -1;
endpackage

// File: rtl/signal_history_tracker_ts_window_match.sv
// ts_window_match: flags one history entry lying inside an inclusive window
//   ts, valid: stored timestamp and its valid bit; win: [1] start, [0] end; hit: entry matches
module ts_window_match
    import signal_history_tracker_pkg::*;
(
    input  ts_t     ts,
    input  logic    valid,
    input  window_t win,
    output logic    hit
);
    ts_t lo, hi;
    assign lo = win[1];
    assign hi = win[0];
    assign hit = valid && ts >= lo && ts <= hi;
endmodule

// File: rtl/signal_history_tracker.sv
// signal_history_tracker: circular timestamp history of one status bit with window presence / first-hit queries
//   clk, rst (sync, active-low); counter: current cycle count; tracked_signal/ready_flag/
//   ex_ready_flag/data_mem_req_flag: record control; range_in: query window;
//   recalculate_range -> range_out: any hit; recalculate_single_cycle -> single_cycle_out: first hit or -1
module signal_history_tracker
    import signal_history_tracker_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic    clk,
    input  logic    rst,
    input  ts_t     counter,
    input  logic    tracked_signal,
    input  logic    ready_flag,
    input  logic    ex_ready_flag,
    input  logic    data_mem_req_flag,
    input  window_t range_in,
    input  logic    recalculate_range,
    output logic    range_out,
    input  logic    recalculate_single_cycle,
    output ts_t     single_cycle_out
);
    localparam int AW = $clog2(DEPTH);
    ts_t              mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] hit;
    logic [AW-1:0]    wptr;
    logic             cond, cond_q, do_rec, any_hit, range_q, found;
    ts_t              min_hit, single_q;
    assign cond    = tracked_signal & ready_flag & ~data_mem_req_flag;
    assign do_rec  = cond & ~(ex_ready_flag & cond_q);
    assign any_hit = |hit;
    // the slot being written this cycle is hidden from the query
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        ts_window_match u_match (
            .ts   (mem[i]),
            .valid(valid[i] & ~(do_rec & (wptr == AW'(i)))),
            .win  (range_in),
            .hit  (hit[i])
        );
    end
    always_comb begin
        min_hit = NO_MATCH;
        found   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i] && (!found || mem[i] < min_hit)) begin
                min_hit = mem[i];
                found   = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (do_rec) mem[wptr] <= counter;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid    <= '0;
            wptr     <= '0;
            cond_q   <= 1'b0;
            range_q  <= 1'b0;
            single_q <= NO_MATCH;
        end else begin
            cond_q <= cond;
            if (do_rec) begin
                valid[wptr] <= 1'b1;
                wptr        <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (recalculate_range) range_q <= any_hit;
            if (recalculate_single_cycle) single_q <= min_hit;
        end
    end
    // answer combinationally in the pulse cycle, hold the registered result otherwise
    assign range_out        = !rst ? 1'b0 : recalculate_range ? any_hit : range_q;
    assign single_cycle_out = !rst ? NO_MATCH : recalculate_single_cycle ? min_hit : single_q;
endmodule

// File: tb/tb_signal_history_tracker.sv
// tb_signal_history_tracker: table-driven query checks with a scoreboard of expected answers
module tb_signal_history_tracker;
    import signal_history_tracker_pkg::*;
    logic    clk = 1'b0;
    logic    rst = 1'b0;
    ts_t     counter = '0;
    logic    tracked_signal = 1'b0, ready_flag = 1'b1, ex_ready_flag = 1'b0, data_mem_req_flag = 1'b0;
    logic    recalculate_range = 1'b0, recalculate_single_cycle = 1'b0;
    window_t range_in = '0;
    logic    range_out;
    ts_t     single_cycle_out;

    signal_history_tracker #(.DEPTH(128)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .counter                 (counter),
        .tracked_signal          (tracked_signal),
        .ready_flag              (ready_flag),
        .ex_ready_flag           (ex_ready_flag),
        .data_mem_req_flag       (data_mem_req_flag),
        .range_in                (range_in),
        .recalculate_range       (recalculate_range),
        .range_out               (range_out),
        .recalculate_single_cycle(recalculate_single_cycle),
        .single_cycle_out        (single_cycle_out)
    );

    always #5 clk = ~clk;

    typedef struct {int ph; int lo; int hi; bit pr; bit ps; int er; int es;} vec_t;
    typedef struct {bit r; int s;} exp_t;
    vec_t v[$];
    exp_t sb[$];
    int   compared = 0, mismatched = 0;
    bit   m_r = 1'b0;
    int   m_s = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // starts and ends just after a falling edge
    task automatic query(input string name, input int lo, input int hi, input bit pr, input bit ps,
                         input int er, input int es);
        exp_t e;
        range_in[1] = lo;
        range_in[0] = hi;
        recalculate_range = pr;
        recalculate_single_cycle = ps;
        if (pr) m_r = er[0];
        if (ps) m_s = es;
        e.r = m_r;
        e.s = m_s;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk({name, " comb range_out"}, {31'b0, range_out}, {31'b0, e.r});
        chk({name, " comb single_cycle_out"}, single_cycle_out, e.s);
        @(negedge clk);
        recalculate_range = 1'b0;
        recalculate_single_cycle = 1'b0;
        range_in = '0;
        #1;
        chk({name, " held range_out"}, {31'b0, range_out}, {31'b0, m_r});
        chk({name, " held single_cycle_out"}, single_cycle_out, m_s);
    endtask

    task automatic run_phase(input int p);
        foreach (v[i]) if (v[i].ph == p)
            query($sformatf("ph%0d[%0d,%0d]", p, v[i].lo, v[i].hi), v[i].lo, v[i].hi,
                  v[i].pr, v[i].ps, v[i].er, v[i].es);
    endtask

    task automatic rec(input int c, input bit sig = 1, input bit rdy = 1, input bit ex = 0, input bit dmr = 0);
        counter = c;
        tracked_signal = sig;
        ready_flag = rdy;
        ex_ready_flag = ex;
        data_mem_req_flag = dmr;
        @(negedge clk);
    endtask

    task automatic idle();
        tracked_signal = 1'b0;
        ready_flag = 1'b1;
        ex_ready_flag = 1'b0;
        data_mem_req_flag = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        v = '{
            '{0, 0, 100, 1, 1, 0, -1},
            '{1, 11, 40, 1, 1, 1, 11},
            '{1, 12, 39, 1, 1, 0, -1},
            '{1, 0, 100, 1, 1, 1, 10},
            '{1, 41, 1000, 1, 1, 0, -1},
            '{2, 21, 25, 1, 1, 0, -1},
            '{2, 20, 20, 1, 1, 1, 20},
            '{3, 30, 30, 1, 1, 0, -1},
            '{3, 31, 31, 1, 1, 0, -1},
            '{5, 0, 100, 1, 1, 0, -1},
            '{6, 0, 71, 1, 1, 0, -1},
            '{6, 72, 72, 1, 1, 1, 72},
            '{6, 190, 199, 1, 1, 1, 190},
            '{6, 0, 71, 1, 0, 0, 0},
            '{6, 199, 199, 0, 1, 0, 199},
            '{6, -5, 1000, 1, 1, 1, 72}
        };
        repeat (3) @(negedge clk);
        #1;
        chk("reset range_out", {31'b0, range_out}, 32'd0);
        chk("reset single_cycle_out", single_cycle_out, -32'sd1);
        rst = 1'b1;
        @(negedge clk);
        run_phase(0);
        rec(10); rec(11); idle(); rec(40); idle();
        run_phase(1);
        for (int c = 20; c <= 25; c++) rec(c, 1, 1, 1, 0);
        idle();
        run_phase(2);
        rec(30, 1, 1, 0, 1); rec(31, 1, 0, 0, 0); idle();
        run_phase(3);
        counter = 50;
        tracked_signal = 1'b1;
        query("same-cycle [50,50]", 50, 50, 1, 1, 0, -1);
        tracked_signal = 1'b0;
        query("next-cycle [50,50]", 50, 50, 1, 1, 1, 50);
        query("reversed [60,50]", 60, 50, 1, 1, 0, -1);
        query("pre-reset [0,100]", 0, 100, 1, 1, 1, 10);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_r = 1'b0;
        m_s = -1;
        run_phase(5);
        for (int c = 0; c < 200; c++) rec(c);
        idle();
        run_phase(6);
        rst = 1'b0;
        m_r = 1'b0;
        m_s = -1;
        query("reset-during-pulse", 0, 1000, 1, 1, 0, -1);
        rst = 1'b1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
